data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory that serves RISC-V style loads/stores over a valid/ready
// request channel, with a fixed number of wait states before each response.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
   // a response transfers on a rising edge with rsp_valid && rsp_ready; once raised,
   // rsp_valid and its payload hold until that transfer.

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q,     state_d;
   logic [3:0]  cnt_q,       cnt_d;
   logic        write_q,     write_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [2:0]  funct3_q,    funct3_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q,   rsp_err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [1:0]    lane;
   logic [29:0]   word_addr;
   logic [AW-1:0] word_idx;
   logic          funct_ok;
   logic          misaligned;
   logic          out_of_range;
   logic          acc_err;
   logic [31:0]   mem_word;
   logic [31:0]   ld_shift;
   logic [31:0]   load_data;
   logic [3:0]    st_be;
   logic [31:0]   st_data;
   logic          mem_we;

   // Access decode always works on the captured request, never on live inputs.
   always_comb begin
      lane         = addr_q[1:0];
      word_addr    = addr_q[31:2];
      word_idx     = word_addr[AW-1:0];
      out_of_range = ({2'b00, word_addr} >= 32'(DEPTH_WORDS));
      if (write_q) funct_ok = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
      else         funct_ok = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                              (funct3_q == 3'b100) || (funct3_q == 3'b101);
      misaligned   = ((funct3_q[1:0] == 2'b01) && lane[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (lane != 2'b00));
      acc_err      = !funct_ok || misaligned || out_of_range;

      mem_word  = mem[word_idx];
      ld_shift  = mem_word >> {lane, 3'b000};
      load_data = 32'h0;
      case (funct3_q)
         3'b000:  load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  load_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b010:  load_data = mem_word;
         3'b100:  load_data = {24'h0, ld_shift[7:0]};
         3'b101:  load_data = {16'h0, ld_shift[15:0]};
         default: load_data = 32'h0;
      endcase

      st_be   = 4'b0000;
      st_data = wdata_q;
      case (funct3_q)
         3'b000: begin
            st_be   = 4'b0001 << lane;
            st_data = {4{wdata_q[7:0]}};
         end
         3'b001: begin
            st_be   = 4'b0011 << lane;
            st_data = {2{wdata_q[15:0]}};
         end
         3'b010:  st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               cnt_d    = WAIT_LD;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // WAIT spans WAIT_CYCLES wait states plus one access cycle, so the
            // response appears WAIT_CYCLES+1 edges after acceptance.
            if (cnt_q == 4'd0) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = acc_err;
               rsp_rdata_d = (acc_err || write_q) ? 32'h0 : load_data;
               mem_we      = write_q && !acc_err;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         funct3_q    <= 3'b000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         funct3_q    <= funct3_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage has no reset; a store is only committed by the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (st_be[k]) mem[word_idx][8*k +: 8] <= st_data[8*k +: 8];
         end
      end
   end

   assign req_ready = (state_q == S_IDLE) && rst_n;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a byte-addressed reference memory predicts every
// response, a negedge compare process checks the outputs each cycle, literals pin the model.
module tb_data_mem_responder;

   localparam int W     = 2;
   localparam int DEPTH = 64;
   localparam int EW    = 65;   // {due_cycle[31:0], err, rdata[31:0]}

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  dbg_state;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [7:0]    mdl_byte[logic [31:0]];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference access: byte-level memory, size from funct3, sign rules applied arithmetically.
   task automatic mdl_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f3, output logic err, output logic [31:0] rd);
      int size;
      logic legal;
      logic [31:0] v;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err = !legal || ((a % size) != 0) || ((a / 4) >= DEPTH);
      rd = 32'h0;
      if (!err && w) begin
         for (int i = 0; i < size; i++) mdl_byte[a + i] = 8'(wd >> (8 * i));
      end else if (!err) begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(mdl_byte[a + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
         rd = v;
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst_n) begin
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_req_ready", 32'(req_ready), 32'h0);
         chk("rst_rsp_rdata", rsp_rdata, 32'h0);
         chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      end else if (exp_q.size() == 0) begin
         chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("idle_req_ready", 32'(req_ready), 32'h1);
      end else begin
         e = exp_q[0];
         chk("busy_req_ready", 32'(req_ready), 32'h0);
         if (cyc < e[64:33]) begin
            chk("early_rsp_valid", 32'(rsp_valid), 32'h0);
         end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rsp_rdata", rsp_rdata, e[31:0]);
            chk("rsp_err", 32'(rsp_err), 32'(e[32]));
            if (rsp_valid && rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input int hold,
                         input logic [31:0] lit_rd, input logic lit_err);
      int t;
      int seen;
      int unsigned acc;
      logic m_err;
      logic [31:0] m_rd;
      logic [31:0] got_rd;
      logic got_err;
      req_write  = w;
      req_addr   = a;
      req_wdata  = wd;
      req_funct3 = f3;
      req_valid  = 1'b1;
      t = 0;
      while (!req_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
      acc = cyc;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_write  = ~w;
      req_funct3 = 3'(($urandom_range(0, 7)));
      mdl_access(w, a, wd, f3, m_err, m_rd);
      exp_q.push_back({32'(acc + 1 + W), m_err, m_rd});
      seen = 0;
      t = 0;
      got_rd = 32'hx;
      got_err = 1'bx;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk); #1; t++;
         if (exp_q.size() != 0 && rsp_valid) begin
            if (seen == 0) chk("latency", cyc - acc, 32'(1 + W));
            got_rd  = rsp_rdata;
            got_err = rsp_err;
            if (seen >= hold) rsp_ready = 1'b1;
            seen++;
         end
      end
      rsp_ready = 1'b0;
      if (exp_q.size() != 0) begin
         chk("rsp_timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
      end
      chk("lit_rdata", got_rd, lit_rd);
      chk("lit_err", 32'(got_err), 32'(lit_err));
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [2:0]  f3;
      int          hold;
      logic [31:0] lit_rd;
      logic        lit_err;
   } vec_t;

   vec_t vecs[] = '{
      '{1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0,        1'b0},
      '{1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADBEEF, 1'b0},
      '{1'b0, 32'h13, 32'h0,        3'b000, 1, 32'hFFFFFFDE, 1'b0},
      '{1'b0, 32'h13, 32'h0,        3'b100, 0, 32'h000000DE, 1'b0},
      '{1'b0, 32'h10, 32'h0,        3'b001, 2, 32'hFFFFBEEF, 1'b0},
      '{1'b0, 32'h12, 32'h0,        3'b101, 0, 32'h0000DEAD, 1'b0},
      '{1'b1, 32'h11, 32'h00000055, 3'b000, 0, 32'h0,        1'b0},
      '{1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEAD55EF, 1'b0},
      '{1'b1, 32'h12, 32'h00001234, 3'b001, 0, 32'h0,        1'b0},
      '{1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h123455EF, 1'b0},
      '{1'b0, 32'h12, 32'h0,        3'b010, 0, 32'h0,        1'b1},
      '{1'b1, 32'h11, 32'hFFFF,     3'b001, 0, 32'h0,        1'b1},
      '{1'b0, 32'h10, 32'h0,        3'b011, 0, 32'h0,        1'b1},
      '{1'b0, 32'h100, 32'h0,       3'b010, 0, 32'h0,        1'b1},
      '{1'b1, 32'h100, 32'h1,       3'b010, 0, 32'h0,        1'b1},
      '{1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 0, 32'h0,        1'b1},
      '{1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h123455EF, 1'b0},
      '{1'b1, 32'hFC, 32'h0BADF00D, 3'b010, 0, 32'h0,        1'b0},
      '{1'b0, 32'hFC, 32'h0,        3'b010, 3, 32'h0BADF00D, 1'b0},
      '{1'b0, 32'h10, 32'h0,        3'b000, 5, 32'hFFFFFFEF, 1'b0},
      '{1'b1, 32'h20, 32'hA5A5A5A5, 3'b010, 0, 32'h0,        1'b0}
   };

   initial begin
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_funct3 = 3'b000;
      rsp_ready  = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("ready_after_reset", 32'(req_ready), 32'h1);

      foreach (vecs[i])
         do_req(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].f3, vecs[i].hold, vecs[i].lit_rd, vecs[i].lit_err);

      // Store accepted, then reset while it is still waiting: it must never land.
      req_write  = 1'b1;
      req_addr   = 32'h20;
      req_wdata  = 32'h1;
      req_funct3 = 3'b010;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      exp_q.push_back({32'(cyc + 1000), 1'b0, 32'h0});
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("abort_req_ready", 32'(req_ready), 32'h0);
      chk("abort_rsp_rdata", rsp_rdata, 32'h0);
      chk("abort_rsp_err", 32'(rsp_err), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("ready_after_abort", 32'(req_ready), 32'h1);

      do_req(1'b0, 32'h20, 32'h0,    3'b010, 0, 32'hA5A5A5A5, 1'b0);
      do_req(1'b1, 32'h22, 32'h8001, 3'b001, 0, 32'h0,        1'b0);
      do_req(1'b0, 32'h22, 32'h0,    3'b001, 0, 32'hFFFF8001, 1'b0);
      do_req(1'b0, 32'h20, 32'h0,    3'b101, 0, 32'h0000A5A5, 1'b0);
      do_req(1'b0, 32'h21, 32'h0,    3'b001, 0, 32'h0,        1'b1);
      do_req(1'b0, 32'h20, 32'h0,    3'b110, 0, 32'h0,        1'b1);
      do_req(1'b0, 32'h20, 32'h0,    3'b010, 0, 32'h8001A5A5, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
